// File: rtl/led_show_pkg.sv
// Shared types and helpers for the LED show sequencer.
// This package holds the mode codes, the FSM states and the pattern helper functions.
package led_show_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ALT   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_CHASE = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FILL  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BLINK = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    // Unused codes 5-7 collapse to OFF so the bank never shows an undefined pattern.
    function automatic logic [MODE_W-1:0] legal_mode(input logic [MODE_W-1:0] code);
        return (code > MODE_BLINK) ? MODE_OFF : code;
    endfunction

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] mode);
        case (mode)
            MODE_ALT:   return MODE_CHASE;
            MODE_CHASE: return MODE_FILL;
            MODE_FILL:  return MODE_BLINK;
            MODE_BLINK: return MODE_ALT;
            default:    return MODE_OFF;
        endcase
    endfunction

    // Initial value of LED bit_idx for a mode.
    // The caller loops this over N_LEDS, so the function works for any bank width.
    function automatic logic init_pattern(input logic [MODE_W-1:0] mode, input int bit_idx);
        case (mode)
            MODE_ALT:              return bit_idx[0];
            MODE_CHASE, MODE_FILL: return (bit_idx == 0);
            MODE_BLINK:            return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/led_show_if.sv
// Host-side bundle of the LED show sequencer.
// It carries the enables, the mode request handshake and the LED/status outputs.
interface led_show_if
    import led_show_pkg::*;
#(
    parameter int N_LEDS = 28
);
    logic              en;
    logic              auto_en;
    logic              req_valid;
    logic [MODE_W-1:0] req_mode;
    logic              req_ready;
    logic [N_LEDS-1:0] led;
    logic [MODE_W-1:0] cur_mode;
    logic              tick;

    modport master (
        output en, auto_en, req_valid, req_mode,
        input  req_ready, led, cur_mode, tick
    );

    modport slave (
        input  en, auto_en, req_valid, req_mode,
        output req_ready, led, cur_mode, tick
    );
endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running divider that produces one pattern tick every TICK_DIV cycles while run is high.
// The clear input restarts the count so that a new pattern gets a full first period.
module led_tick_prescaler #(
    parameter int TICK_DIV = 49999997
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    // NOTE: every path below starts from a default, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && (count_q == LAST);

endmodule

// File: rtl/led_show_sequencer.sv
// LED bank scheduler: it selects the blink pattern, steps the pattern on each prescaler tick,
// rotates through the modes automatically and accepts forced modes from a host.
module led_show_sequencer #(
    parameter int N_LEDS     = 28,
    parameter int TICK_DIV   = 49999997,
    parameter int SHOW_TICKS = 16
) (
    input logic       clk,
    input logic       rst,
    led_show_if.slave bus
);
    import led_show_pkg::*;

    localparam int DW = $clog2(SHOW_TICKS) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SHOW_TICKS - 1);

    state_e            state_q;
    logic [N_LEDS-1:0] led_q;
    logic [MODE_W-1:0] cur_mode_q;
    logic [DW-1:0]     dwell_q;
    logic [N_LEDS-1:0] init_led_d;
    logic [N_LEDS-1:0] step_led_d;
    logic              tick;

    led_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q != ST_RUN),
        .run  (state_q == ST_RUN),
        .tick (tick)
    );

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            init_led_d[i] = init_pattern(cur_mode_q, i);
        end
    end

    always_comb begin
        step_led_d = '0;
        case (cur_mode_q)
            MODE_ALT, MODE_BLINK: step_led_d = ~led_q;
            MODE_CHASE:           step_led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            MODE_FILL:            step_led_d = (&led_q) ? '0 : {led_q[N_LEDS-2:0], 1'b1};
            default:              step_led_d = '0;
        endcase
    end

    // The order of priority is: en low first, then a host request, then auto-advance, then the normal pattern step.
    // NOTE: state is assigned non-blocking so that every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            cur_mode_q <= MODE_OFF;
            dwell_q    <= '0;
        end else if (!bus.en) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_q      <= '0;
                    cur_mode_q <= MODE_ALT;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: begin
                    led_q   <= init_led_d;
                    dwell_q <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.req_valid) begin
                        cur_mode_q <= legal_mode(bus.req_mode);
                        state_q    <= ST_LOAD;
                    end else if (tick) begin
                        if (bus.auto_en && (dwell_q == DWELL_LAST)) begin
                            cur_mode_q <= next_mode(cur_mode_q);
                            dwell_q    <= '0;
                            state_q    <= ST_LOAD;
                        end else begin
                            led_q   <= step_led_d;
                            // The dwell count wraps, so it stays bounded while auto-advance is off.
                            dwell_q <= (dwell_q == DWELL_LAST) ? '0 : dwell_q + DW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.led       = led_q;
    assign bus.cur_mode  = cur_mode_q;
    assign bus.req_ready = (state_q == ST_RUN);
    assign bus.tick      = tick;

endmodule

// File: doc/led_show_sequencer.md
Name: led_show_sequencer

Overview:
Scheduler that owns the LED bank and decides which blink pattern drives it, and for how long. A built-in prescaler produces a pattern tick every TICK_DIV cycles. The block auto-rotates through pattern modes after SHOW_TICKS ticks each. A valid/ready request port lets a host (button handler, UART command decoder) force a specific mode at any time.

Parameters:
N_LEDS, 28, width of LED bank (minimum 2)
TICK_DIV, 49999997, clk cycles per pattern tick (minimum 2)
SHOW_TICKS, 16, ticks spent in each mode before auto-advance (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  level enable; 0 forces LEDs dark and idles the block
auto_en  in  1  1 = auto-advance modes after SHOW_TICKS ticks
req_valid  in  1  host mode request valid
req_mode  in  3  requested mode code
req_ready  out  1  request accept; equals (state==RUN)
led  out  N_LEDS  LED drive, registered, bit i = LED i
cur_mode  out  3  active mode code, registered
tick  out  1  one-cycle pulse at each pattern tick, only while in RUN

Behaviour:
- Mode codes:
  - 0 OFF: led held at 0.
  - 1 ALT: LEDs alternate; invert whole bank each tick.
  - 2 CHASE: single lit LED rotates left; bit N-1 wraps to bit0.
  - 3 FILL: if led is all ones, next is 0; else shift left with 1 shifted into bit0.
  - 4 BLINK: invert whole bank each tick.
  - Codes 5-7 map to OFF when accepted.
- Reset: led=0, cur_mode=0, state=IDLE, prescaler=0, dwell=0, tick=0. req_ready=0 because state is IDLE.
- States:
  - IDLE: led=0. When en=1, cur_mode<=1, next state LOAD.
  - LOAD: one cycle. Load the initial pattern:
    - OFF: 0.
    - ALT: even bits 0, odd bits 1.
    - CHASE: bit0 only.
    - FILL: bit0 only.
    - BLINK: all ones.
  - LOAD also clears prescaler and dwell; next state RUN.
  - RUN: prescaler counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1. On tick, led updates per mode and dwell increments.
- Auto-advance: on a tick where auto_en=1 and dwell==SHOW_TICKS-1:
  - Next mode follows 1->2->3->4->1; OFF stays OFF (dwell still wraps to 0).
  - The pattern update for that tick is skipped; next state is LOAD.
- Request:
  - Handshake completes when req_valid && req_ready in RUN at cycle T.
  - At T+1: cur_mode=req_mode (or 0 if illegal), state=LOAD.
  - At T+2: led shows the initial pattern.
  - A request outranks a same-cycle tick or auto-advance; that tick's led update and dwell increment are discarded, but tick still pulses.
  - Requests in IDLE/LOAD are not accepted. req_valid may be held until ready.
- en deassert: from any state, next cycle is IDLE with led=0. cur_mode is retained until the next en, which restarts at mode 1.
- auto_en toggled mid-mode: only sampled at ticks; dwell keeps counting.
- rst mid-operation: all reset values next cycle regardless of state or handshake.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits; dwell is $clog2(SHOW_TICKS)+1 bits.
  - All compares are unsigned, with no overflow reachable.

Decomposition:
- Package led_show_pkg: mode code constants (MODE_OFF..MODE_BLINK), state encoding (IDLE, LOAD, RUN), next_mode function, init_pattern function parameterised by N_LEDS.
- Sub-module led_tick_prescaler:
  - Inputs: clk, rst, clear, run.
  - Output: tick.
  - Parameter: TICK_DIV.
  - Reused by other blink designs.

Test Plan:
(Use N_LEDS=8, TICK_DIV=4, SHOW_TICKS=3.)
- Reset then en=1, auto_en=0:
  - Cycle 1 IDLE->LOAD; cycle 2 led=8'hAA, cur_mode=1.
  - tick every 4 cycles in RUN; led alternates 8'h55/8'hAA indefinitely.
- auto_en=1 from ALT:
  - After 3 ticks, cur_mode=2 and led=8'h01; then 8'h02, 8'h04.
  - Then FILL: 8'h01, 8'h03, 8'h07.
  - Then BLINK: 8'hFF, 8'h00, 8'hFF.
  - Then back to ALT 8'hAA.
- CHASE wrap: request mode 2 with SHOW_TICKS large; after 7 ticks led=8'h80, next tick 8'h01.
- Request collides with tick: req_valid=1, req_mode=3 in the tick cycle.
  - tick pulses, led not updated.
  - Next cycle cur_mode=3; following cycle led=8'h01.
  - FILL reaches 8'hFF, then 8'h00.
- Illegal request req_mode=6 -> cur_mode=0, led=0, req_ready stays 1 in RUN. en=0 mid-RUN -> next cycle led=0, req_ready=0.
- rst asserted mid-handshake (req_valid=1) -> next cycle led=0, cur_mode=0, req_ready=0, tick=0.
